// File: rtl/gridding_pkg.sv
// Shared constants and types for the gridding datapath: row geometry, adder latency,
// accumulator FSM states and the in-flight tracker entry.
package gridding_pkg;

    localparam int unsigned COMPLEX         = 2;
    localparam int unsigned PRECISION       = 32;
    localparam int unsigned PARALLELISM     = 15;
    localparam int unsigned BRAM_DEPTH_BITS = 10;
    localparam int unsigned ADD_LATENCY     = 8;
    localparam int unsigned DATA_PATH_WIDTH = PARALLELISM * PRECISION * COMPLEX;

    // One stage per cycle from accept to write-back inclusive.
    localparam int unsigned TRACK_DEPTH = ADD_LATENCY + 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        CLEAR
    } state_e;

    typedef struct packed {
        logic                       valid;
        logic [BRAM_DEPTH_BITS-1:0] addr;
    } track_entry_t;

endpackage

// File: rtl/inflight_tracker.sv
// Shift register of {valid, addr} for rows travelling through the read/add pipeline,
// with a parallel address match against every stage.
module inflight_tracker
    import gridding_pkg::*;
#(
    parameter int unsigned DEPTH = TRACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [BRAM_DEPTH_BITS-1:0] push_addr,
    input  logic [BRAM_DEPTH_BITS-1:0] lookup_addr,
    output logic                       hit,
    output logic                       empty,
    output logic                       tail_valid,
    output logic [BRAM_DEPTH_BITS-1:0] tail_addr
);

    track_entry_t [DEPTH-1:0] stage_q;
    track_entry_t [DEPTH-1:0] stage_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        stage_d          = '0;
        stage_d[0].valid = push;
        stage_d[0].addr  = push_addr;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // The tail stage is the one being written back; it still blocks its address.
    always_comb begin
        hit   = 1'b0;
        empty = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (stage_q[i].valid) begin
                empty = 1'b0;
                if (stage_q[i].addr == lookup_addr) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign tail_valid = stage_q[DEPTH-1].valid;
    assign tail_addr  = stage_q[DEPTH-1].addr;

endmodule

// File: rtl/grid_accumulator.sv
// Read-modify-write controller for the grid BRAM: reads the stored row, feeds the
// external adder array, writes the sum back, and can sweep the whole grid to zero.
module grid_accumulator
    import gridding_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BRAM_DEPTH_BITS-1:0] in_addr,
    input  logic [DATA_PATH_WIDTH-1:0] in_data,
    input  logic                       clear_start,
    output logic                       busy,
    output logic                       rd_en,
    output logic [BRAM_DEPTH_BITS-1:0] rd_addr,
    input  logic [DATA_PATH_WIDTH-1:0] rd_data,
    output logic [DATA_PATH_WIDTH-1:0] add_a,
    output logic [DATA_PATH_WIDTH-1:0] add_b,
    input  logic [DATA_PATH_WIDTH-1:0] add_o,
    output logic                       add_sclr,
    output logic                       wr_en,
    output logic [BRAM_DEPTH_BITS-1:0] wr_addr,
    output logic [DATA_PATH_WIDTH-1:0] wr_data
);

    state_e                     state_q, state_d;
    logic [BRAM_DEPTH_BITS-1:0] cnt_q, cnt_d;
    logic [DATA_PATH_WIDTH-1:0] data_q;
    logic                       rd_pending_q;
    logic                       sclr_q;

    logic                       accept;
    logic                       hit;
    logic                       empty;
    logic                       tail_valid;
    logic [BRAM_DEPTH_BITS-1:0] tail_addr;

    assign accept = in_valid & in_ready;

    inflight_tracker #(
        .DEPTH(TRACK_DEPTH)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept),
        .push_addr  (in_addr),
        .lookup_addr(in_addr),
        .hit        (hit),
        .empty      (empty),
        .tail_valid (tail_valid),
        .tail_addr  (tail_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (clear_start) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (empty) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + BRAM_DEPTH_BITS'(1);
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = (state_q != RUN) | ~empty;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        unique case (state_q)
            RUN: begin
                // sclr_q doubles as the "first edge after reset not yet seen" flag.
                in_ready = ~sclr_q & ~clear_start & ~hit;
                wr_en    = tail_valid;
                if (tail_valid) begin
                    wr_addr = tail_addr;
                    wr_data = add_o;
                end
            end
            DRAIN: begin
                wr_en = tail_valid;
                if (tail_valid) begin
                    wr_addr = tail_addr;
                    wr_data = add_o;
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
            end
            default: ;
        endcase
    end

    assign rd_en    = accept;
    assign rd_addr  = accept ? in_addr : '0;
    assign add_a    = rd_pending_q ? rd_data : '0;
    assign add_b    = data_q;
    assign add_sclr = sclr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclr_q       <= 1'b1;
            rd_pending_q <= 1'b0;
            data_q       <= '0;
        end else begin
            sclr_q       <= 1'b0;
            rd_pending_q <= accept;
            if (accept) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_grid_accumulator.sv
// Bench for grid_accumulator: BRAM and float adder stand-ins plus a queue-based model
// of pending accumulations and the zeroing sweep, checked every cycle.
module tb_grid_accumulator;
    import gridding_pkg::*;

    localparam int unsigned DW    = DATA_PATH_WIDTH;
    localparam int unsigned AW    = BRAM_DEPTH_BITS;
    localparam int          LANES = int'(DW / 32);
    localparam int          NROWS = 1 << AW;
    localparam int          LAT   = int'(ADD_LATENCY) + 1;

    logic          clk, rst_n, in_valid, in_ready, clear_start, busy, rd_en, add_sclr, wr_en;
    logic [AW-1:0] in_addr, rd_addr, wr_addr;
    logic [DW-1:0] in_data, rd_data, add_a, add_b, add_o, wr_data;

    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] mem [NROWS];
    logic [DW-1:0] rd_q;
    logic [DW-1:0] pipe [ADD_LATENCY];

    grid_accumulator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .clear_start(clear_start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .add_a(add_a), .add_b(add_b),
        .add_o(add_o), .add_sclr(add_sclr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        real r;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        e = int'(f[30:23]) - 127;
        r = 1.0 + real'(f[22:0]) / 8388608.0;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return f[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [DW-1:0] add_rows(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            r[k*32 +: 32] = r2f(f2r(a[k*32 +: 32]) + f2r(b[k*32 +: 32]));
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] row_const(input logic [31:0] v);
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*32 +: 32] = r2f(real'($urandom_range(8, 1)));
        return r;
    endfunction

    // Read-first BRAM with a backdoor preload port.
    always @(posedge clk) begin
        if (rd_en) rd_q <= mem[rd_addr];
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (wr_en) mem[wr_addr] <= wr_data;
    end
    assign rd_data = rd_q;

    always @(posedge clk) begin
        pipe[0] <= add_rows(add_a, add_b);
        for (int i = 1; i < int'(ADD_LATENCY); i++) pipe[i] <= pipe[i-1];
    end
    assign add_o = pipe[ADD_LATENCY-1];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            acc;
        int            due;
    } pend_t;

    pend_t         q[$];
    logic [DW-1:0] grid [NROWS];
    int            n_cmp, n_bad, cyc;
    logic          m_clr, rst_prev, acc_now;
    int            clr_begin, clr_end;
    int            wr_cnt, zero_cnt, last_acc_cyc, last_wr_cyc;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_row(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int k = 0; k < LANES; k++) begin
                if (act[k*32 +: 32] !== exp[k*32 +: 32]) begin
                    $display("FAIL %s @cyc %0d lane %0d: got 0x%h, want 0x%h", nm, cyc, k,
                             act[k*32 +: 32], exp[k*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    // One cycle of the reference model, evaluated mid-cycle while inputs are stable.
    task automatic step();
        logic          sclr_exp, hazard, exp_ready, exp_busy, exp_wr;
        logic [AW-1:0] exp_waddr;
        logic [DW-1:0] exp_wdata;
        pend_t         p;
        int            last;
        acc_now = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_clr = 1'b0;
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_rd_en", 64'(rd_en), 64'd0);
            chk("rst_wr_en", 64'(wr_en), 64'd0);
            chk("rst_add_sclr", 64'(add_sclr), 64'd1);
            chk("rst_addrs", {32'(rd_addr), 32'(wr_addr)}, 64'd0);
            chk_row("rst_wr_data", wr_data, '0);
            chk_row("rst_add_a", add_a, '0);
            chk_row("rst_add_b", add_b, '0);
            rst_prev = 1'b0;
            cyc++;
            return;
        end
        sclr_exp = !rst_prev;
        while (q.size() > 0 && q[0].due < cyc) q.delete(0);
        if (m_clr && cyc > clr_end) m_clr = 1'b0;
        hazard   = 1'b0;
        exp_busy = m_clr;
        foreach (q[i]) begin
            if (q[i].acc < cyc) begin
                exp_busy = 1'b1;
                if (q[i].addr == in_addr) hazard = 1'b1;
            end
        end
        exp_ready = !m_clr && !sclr_exp && !clear_start && !hazard;
        exp_wr    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_wr    = 1'b1;
            exp_waddr = q[0].addr;
            exp_wdata = q[0].data;
        end else if (m_clr && cyc >= clr_begin) begin
            exp_wr    = 1'b1;
            exp_waddr = AW'(cyc - clr_begin);
        end
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("add_sclr", 64'(add_sclr), 64'(sclr_exp));
        chk("wr_en", 64'(wr_en), 64'(exp_wr));
        chk("rd_en", 64'(rd_en), 64'(in_valid && exp_ready));
        if (exp_wr) begin
            chk("wr_addr", 64'(wr_addr), 64'(exp_waddr));
            chk_row("wr_data", wr_data, exp_wdata);
            grid[exp_waddr] = exp_wdata;
        end
        if (in_valid && exp_ready) chk("rd_addr", 64'(rd_addr), 64'(in_addr));
        if (wr_en) begin
            wr_cnt++;
            if (wr_data == '0) zero_cnt++;
            last_wr_cyc  = cyc;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
        if (in_valid && exp_ready) begin
            acc_now      = 1'b1;
            last_acc_cyc = cyc;
            p.addr = in_addr;
            p.data = add_rows(grid[in_addr], in_data);
            p.acc  = cyc;
            p.due  = cyc + LAT;
            q.push_back(p);
        end
        if (clear_start && !m_clr) begin
            last      = (q.size() > 0) ? q[q.size()-1].due : cyc;
            clr_begin = ((cyc + 1 > last + 1) ? cyc + 1 : last + 1) + 1;
            clr_end   = clr_begin + NROWS - 1;
            m_clr     = 1'b1;
        end
        rst_prev = 1'b1;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input int bound);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (acc_now) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        n_bad++;
        $display("FAIL push_timeout: addr %0d not accepted within %0d cycles", a, bound);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!m_clr && q.size() == 0) return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL idle_timeout: still busy after %0d cycles", bound);
    endtask

    task automatic pulse_clear();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
    endtask

    initial begin
        int a1, a2, acc, w0, z0;
        n_cmp = 0; n_bad = 0; cyc = 0;
        m_clr = 1'b0; rst_prev = 1'b0; acc_now = 1'b0;
        clr_begin = 0; clr_end = 0;
        wr_cnt = 0; zero_cnt = 0; last_acc_cyc = 0; last_wr_cyc = 0;
        last_wr_addr = '0; last_wr_data = '0;
        for (int r = 0; r < NROWS; r++) grid[r] = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; clear_start = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;

        repeat (3) tick();
        chk("sclr_in_reset", 64'(add_sclr), 64'd1);
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", 64'(in_ready), 64'd1);

        // Zero the BRAM through the design itself before any accumulation.
        pulse_clear();
        wait_idle(1200);

        // Single row: 1.0 + 2.0 at address 5.
        pre_en = 1'b1; pre_addr = AW'(5); pre_data = row_const(32'h3F80_0000);
        grid[5] = row_const(32'h3F80_0000);
        tick();
        pre_en = 1'b0;
        push(AW'(5), row_const(32'h4000_0000), 4);
        wait_idle(20);
        chk("single_addr", 64'(last_wr_addr), 64'd5);
        chk_row("single_data", last_wr_data, row_const(32'h4040_0000));
        chk("single_latency", 64'(last_wr_cyc - last_acc_cyc), 64'd9);

        // Same address back-to-back into a zeroed row.
        push(AW'(7), row_const(32'h3F80_0000), 4);
        a1 = last_acc_cyc;
        push(AW'(7), row_const(32'h3F80_0000), 20);
        a2 = last_acc_cyc;
        chk("same_addr_gap", 64'(a2 - a1), 64'd10);
        wait_idle(20);
        chk_row("row7_bram", mem[7], row_const(32'h4000_0000));
        chk_row("row7_model", grid[7], row_const(32'h4000_0000));

        // Distinct addresses at full rate.
        acc = 0;
        w0  = wr_cnt;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_addr  = AW'(i);
            in_data  = rand_row();
            tick();
            if (acc_now) acc++;
        end
        in_valid = 1'b0;
        chk("distinct_accepts", 64'(acc), 64'd32);
        wait_idle(20);
        chk("distinct_writes", 64'(wr_cnt - w0), 64'd32);

        // Clear with three rows in flight, plus an ignored second request mid-sweep.
        w0 = wr_cnt;
        z0 = zero_cnt;
        for (int i = 0; i < 3; i++) push(AW'(100 + i), rand_row(), 4);
        pulse_clear();
        repeat (500) tick();
        pulse_clear();
        wait_idle(800);
        chk("clear_total_writes", 64'(wr_cnt - w0), 64'd1027);
        chk("clear_zero_writes", 64'(zero_cnt - z0), 64'd1024);
        chk_row("row100_cleared", mem[100], '0);
        chk("ready_after_clear", 64'(in_ready), 64'd1);

        // Reset with four rows in flight.
        for (int i = 0; i < 4; i++) push(AW'(200 + i), rand_row(), 4);
        repeat (2) tick();
        w0 = wr_cnt;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("ready_first_edge", 64'(in_ready), 64'd1);
        repeat (15) tick();
        chk("no_write_after_reset", 64'(wr_cnt - w0), 64'd0);

        // Random traffic over a small address window to provoke hazards.
        for (int i = 0; i < 800; i++) begin
            in_valid = ($urandom_range(3, 0) != 0);
            in_addr  = AW'($urandom_range(15, 0));
            in_data  = rand_row();
            tick();
        end
        in_valid = 1'b0;
        wait_idle(20);
        for (int r = 0; r < 16; r++) chk_row("final_row", mem[r], grid[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_accumulator.md
# grid_accumulator

Read-modify-write controller that drives the parallel floating-point `ADDER` array and accumulates incoming visibility-weighted samples into the grid BRAM. Each accepted sample row is added lane-wise to the stored row at its address, and the sum is written back. The block sits between the convolution/sample stage and the grid memory. It owns the in-flight hazard tracking required by the adder's fixed pipeline latency, and a zeroing sweep used between frames.

## Interface
Parameters:
- `COMPLEX`, 2, components per sample (re, im)
- `PRECISION`, 32, bits per float component
- `PARALLELISM`, 15, complex samples per row
- `BRAM_DEPTH_BITS`, 10, grid address width; depth = 2**BRAM_DEPTH_BITS
- `ADD_LATENCY`, 8, `ADDER` pipeline latency in cycles; fixed by core generation
- `DATA_PATH_WIDTH`, PARALLELISM*PRECISION*COMPLEX, row width (derived)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  sample row valid
- `in_ready`  out  1  row accepted when `in_valid & in_ready`
- `in_addr`  in  BRAM_DEPTH_BITS  grid row address
- `in_data`  in  DATA_PATH_WIDTH  row to accumulate
- `clear_start`  in  1  single-cycle request to zero the whole grid
- `busy`  out  1  high in DRAIN/CLEAR or while any accumulation is in flight
- `rd_en`, `rd_addr`  out  1, BRAM_DEPTH_BITS  grid read; `rd_data` valid one cycle later
- `rd_data`  in  DATA_PATH_WIDTH  grid read data (read-first BRAM)
- `add_a`, `add_b`  out  DATA_PATH_WIDTH  adder operands
- `add_o`  in  DATA_PATH_WIDTH  adder result, ADD_LATENCY cycles after operands
- `add_sclr`  out  1  adder synchronous clear
- `wr_en`, `wr_addr`, `wr_data`  out  1, BRAM_DEPTH_BITS, DATA_PATH_WIDTH  grid write

## Operation
- FSM states: RUN (reset state), DRAIN, CLEAR.
- RUN accept path:
  - cycle 0: `rd_en=1`, `rd_addr=in_addr`; `in_data` and `in_addr` are registered.
  - cycle 1: `add_a=rd_data`, `add_b`=registered data.
  - cycle 1+ADD_LATENCY: `wr_en=1`, `wr_addr`=carried address, `wr_data=add_o`.
- In-flight tracker: shift register of {valid, addr}, depth ADD_LATENCY+1. An entry enters on accept and retires on the cycle its `wr_en` is issued. The retiring entry still counts for the hazard compare on that cycle.
- Hazard rule: `in_ready=0` in RUN if `in_addr` matches any valid tracker entry. No forwarding.
- Throughput: one row per cycle for distinct addresses.
- `clear_start` in RUN: go to DRAIN, `in_ready=0`. When the tracker is empty, go to CLEAR.
- CLEAR: write zeros to addresses 0 .. 2**BRAM_DEPTH_BITS-1, one per cycle, with `rd_en=0` throughout. After the last address, return to RUN.
- `clear_start` in DRAIN or CLEAR is ignored.
- `add_sclr`: asynchronously set by reset, cleared on the first `clk` edge after `rst_n` rises.
- No arithmetic in this block; lanes pass through bit-exact. Lane k occupies bits [(k+1)*PRECISION-1 : k*PRECISION].

## Timing
- Outputs while `rst_n=0`:
  - `in_ready=0`, `busy=0`, `rd_en=0`, `wr_en=0`, `add_sclr=1`
  - `rd_addr`, `wr_addr`, `wr_data`, `add_a`, `add_b` are all zero
  - tracker and address counter are zero; state is RUN
- First edge after reset release: `in_ready=1`.
- Accept-to-write latency: ADD_LATENCY+1 cycles.
- Same-address back-to-back: the second row is accepted on the cycle after the first row's write.
  - Gap is ADD_LATENCY+2 cycles between accepts.
  - Its read returns the updated row.
- CLEAR duration: exactly 2**BRAM_DEPTH_BITS cycles of `wr_en`. `busy` falls the cycle after the last zero write.
- `clear_start` and `in_valid` in the same RUN cycle: the row is not accepted; clear takes priority.
- Reset mid-operation: in-flight accumulations are discarded and no write is issued after reset. A partial CLEAR is abandoned.

## Structure
- Shared package `gridding_pkg`:
  - COMPLEX, PRECISION, PARALLELISM, BRAM_DEPTH_BITS, ADD_LATENCY
  - DATA_PATH_WIDTH
  - state enum {RUN, DRAIN, CLEAR}
- One sub-module, `inflight_tracker`:
  - address/valid shift register
  - parallel match compare
  - `empty` output
- The top level instantiates the tracker and the FSM. `ADDER` stays external.

## Test plan
- Single row: grid row 5 = all 0x3F800000 (1.0), push addr 5 with all 0x40000000 (2.0) -> one write to addr 5, all lanes 0x40400000 (3.0), ADD_LATENCY+1 cycles after accept.
- Distinct addresses 0..31 on consecutive cycles -> `in_ready` stays 1, 32 writes in order, 1 per cycle.
- Addr 7 pushed twice back-to-back with 1.0 into a zeroed row -> second accept delayed to ADD_LATENCY+2 cycles after the first; final row 7 = 0x40000000 (2.0).
- `clear_start` with 3 rows in flight -> those 3 writes complete, then 1024 zero writes to 0..1023; `busy` high throughout; `in_ready=0` until done.
- `clear_start` asserted again mid-CLEAR -> ignored; the sweep still completes exactly 1024 writes.
- `rst_n` pulsed low with 4 rows in flight -> no `wr_en` afterwards; all outputs hold their reset values; `in_ready=1` on the first edge after release.
